// File: rtl/alu_issue_queue.sv
// Issue stage in front of the ALU: buffers instructions in a small FIFO and drives
// registered A/B/S/CLR, stalling forwarded instructions until the previous Y is valid.
module alu_issue_queue #(
   parameter int DWIDTH  = 8,
   parameter int OPWIDTH = 4,
   parameter int DEPTH   = 4,
   parameter int ALU_LAT = 2
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_in_valid,
   output logic               o_in_ready,
   input  logic [DWIDTH-1:0]  i_in_a,
   input  logic [DWIDTH-1:0]  i_in_b,
   input  logic [OPWIDTH-1:0] i_in_s,
   input  logic               i_in_clr,
   input  logic               i_in_fwd_a,
   input  logic [DWIDTH-1:0]  i_y,
   output logic [DWIDTH-1:0]  o_a,
   output logic [DWIDTH-1:0]  o_b,
   output logic [OPWIDTH-1:0] o_s,
   output logic               o_clr,
   output logic               o_issue_valid
);

   localparam int PW    = $clog2(DEPTH);
   localparam int CW    = PW + 1;
   localparam int PENDW = $clog2(ALU_LAT) + 1;
   localparam int EW    = 2 * DWIDTH + OPWIDTH + 2;
   localparam logic [CW-1:0]    DEPTH_C   = CW'(DEPTH);
   localparam logic [PENDW-1:0] PEND_LOAD = PENDW'(ALU_LAT - 1);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ISSUE = 2'd1,
      ST_STALL = 2'd2
   } mode_t;

   logic [EW-1:0]      r_mem [DEPTH];
   logic [PW-1:0]      r_wptr;
   logic [PW-1:0]      r_rptr;
   logic [CW-1:0]      r_count;
   logic [PENDW-1:0]   r_pend;

   mode_t              w_mode;
   logic               w_push;
   logic               w_pop;
   logic [EW-1:0]      w_head;
   logic [EW-1:0]      w_wr_entry;
   logic [DWIDTH-1:0]  w_head_a;
   logic [DWIDTH-1:0]  w_head_b;
   logic [OPWIDTH-1:0] w_head_s;
   logic               w_head_clr;
   logic               w_head_fwd;

   // Entry layout, MSB first: {A, B, S, CLR, FWD_A}
   assign w_wr_entry = {i_in_a, i_in_b, i_in_s, i_in_clr, i_in_fwd_a};
   assign w_head     = r_mem[r_rptr];
   assign w_head_a   = w_head[EW-1 -: DWIDTH];
   assign w_head_b   = w_head[EW-DWIDTH-1 -: DWIDTH];
   assign w_head_s   = w_head[OPWIDTH+1 : 2];
   assign w_head_clr = w_head[1];
   assign w_head_fwd = w_head[0];

   assign o_in_ready = (r_count < DEPTH_C) && i_rst_n;
   assign w_push     = i_in_valid && o_in_ready;
   assign w_pop      = (w_mode == ST_ISSUE);

   // Issue decision: only a forwarded head waits on the previous result
   always_comb begin
      w_mode = ST_EMPTY;
      if (r_count == {CW{1'b0}}) begin
         w_mode = ST_EMPTY;
      end else if (w_head_fwd && (r_pend != {PENDW{1'b0}})) begin
         w_mode = ST_STALL;
      end else begin
         w_mode = ST_ISSUE;
      end
   end

   // Entry storage; contents are don't-care until the occupancy count covers them
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= w_wr_entry;
      end
   end

   // Pointers, occupancy and pending-result counter
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wptr  <= {PW{1'b0}};
         r_rptr  <= {PW{1'b0}};
         r_count <= {CW{1'b0}};
         r_pend  <= {PENDW{1'b0}};
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + PW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         if (w_pop) begin
            r_pend <= PEND_LOAD;
         end else if (r_pend != {PENDW{1'b0}}) begin
            r_pend <= r_pend - PENDW'(1);
         end
      end
   end

   // Registered ALU operands; held between issues so the ALU re-executes the last one
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_a           <= {DWIDTH{1'b0}};
         o_b           <= {DWIDTH{1'b0}};
         o_s           <= {OPWIDTH{1'b0}};
         o_clr         <= 1'b1;
         o_issue_valid <= 1'b0;
      end else begin
         o_issue_valid <= w_pop;
         if (w_pop) begin
            o_a   <= w_head_fwd ? i_y : w_head_a;
            o_b   <= w_head_b;
            o_s   <= w_head_s;
            o_clr <= w_head_clr;
         end
      end
   end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue: a registered behavioural ALU closes the Y loop,
// and a queue-based reference model predicts every output cycle by cycle.
module tb_alu_issue_queue;

   localparam int DWIDTH  = 8;
   localparam int OPWIDTH = 4;
   localparam int DEPTH   = 4;
   localparam int ALU_LAT = 2;

   localparam logic [3:0] C_ADD_AB = 4'd0;
   localparam logic [3:0] C_SUB_AB = 4'd1;
   localparam logic [3:0] C_INC_A  = 4'd2;
   localparam logic [3:0] C_AND_AB = 4'd3;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [3:0] s;
      logic       clr;
      logic       fwd;
   } ent_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_a = 8'h00;
   logic [7:0] in_b = 8'h00;
   logic [3:0] in_s = 4'h0;
   logic       in_clr = 1'b0;
   logic       in_fwd = 1'b0;
   logic [7:0] y_r = 8'h00;
   logic [7:0] o_a;
   logic [7:0] o_b;
   logic [3:0] o_s;
   logic       o_clr;
   logic       o_iv;

   int n_cmp = 0;
   int n_err = 0;

   ent_t       q[$];
   logic [7:0] m_a = 8'h00;
   logic [7:0] m_b = 8'h00;
   logic [3:0] m_s = 4'h0;
   logic       m_clr = 1'b1;
   logic       m_iv = 1'b0;
   int         cyc = 0;
   int         last_iss = -1000;

   alu_issue_queue #(
      .DWIDTH(DWIDTH), .OPWIDTH(OPWIDTH), .DEPTH(DEPTH), .ALU_LAT(ALU_LAT)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
      .i_in_a(in_a), .i_in_b(in_b), .i_in_s(in_s), .i_in_clr(in_clr), .i_in_fwd_a(in_fwd),
      .i_y(y_r), .o_a(o_a), .o_b(o_b), .o_s(o_s), .o_clr(o_clr), .o_issue_valid(o_iv)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] s, input logic clr);
      if (clr) return 8'h00;
      case (s)
         C_ADD_AB: return a + b;
         C_SUB_AB: return a - b;
         C_INC_A:  return a + 8'd1;
         C_AND_AB: return a & b;
         default:  return a ^ b;
      endcase
   endfunction

   // One register stage after the operand registers gives Y two edges after issue
   always @(posedge clk) y_r <= alu_f(o_a, o_b, o_s, o_clr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // One clock: drive inputs, advance the model, check outputs after the edge
   task automatic step(input logic rst, input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] s, input logic clr, input logic fwd, output logic acc);
      ent_t e;
      logic rdy;
      logic iss;
      rst_n = rst; in_valid = v; in_a = a; in_b = b; in_s = s; in_clr = clr; in_fwd = fwd;
      #1;
      rdy = rst && (q.size() < DEPTH);
      chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
      acc = 1'b0;
      if (!rst) begin
         q.delete();
         m_a = 8'h00; m_b = 8'h00; m_s = 4'h0; m_clr = 1'b1; m_iv = 1'b0;
         last_iss = -1000;
      end else begin
         iss = (q.size() != 0) && (!q[0].fwd || (cyc - last_iss) >= ALU_LAT);
         if (iss) begin
            e = q.pop_front();
            m_a = e.fwd ? alu_f(m_a, m_b, m_s, m_clr) : e.a;
            m_b = e.b; m_s = e.s; m_clr = e.clr;
            last_iss = cyc;
         end
         m_iv = iss;
         if (v && rdy) begin
            e.a = a; e.b = b; e.s = s; e.clr = clr; e.fwd = fwd;
            q.push_back(e);
            acc = 1'b1;
         end
      end
      cyc++;
      @(posedge clk);
      @(negedge clk);
      chk("a", {24'd0, o_a}, {24'd0, m_a});
      chk("b", {24'd0, o_b}, {24'd0, m_b});
      chk("s", {28'd0, o_s}, {28'd0, m_s});
      chk("clr", {31'd0, o_clr}, {31'd0, m_clr});
      chk("issue_valid", {31'd0, o_iv}, {31'd0, m_iv});
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, acc);
   endtask

   task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s,
                       input logic fwd);
      logic acc;
      int   n;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 20) begin
         step(1'b1, 1'b1, a, b, s, 1'b0, fwd, acc);
         n++;
      end
      if (!acc) chk("push_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      logic acc;
      @(negedge clk);
      // Reset held with an offer pending: nothing is accepted
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'hAA, 8'h55, 4'h1, 1'b0, 1'b0, acc);
      idle(3);

      // Back-to-back issue
      push(8'h05, 8'h03, C_ADD_AB, 1'b0);
      push(8'h10, 8'h01, C_SUB_AB, 1'b0);
      idle(4);
      chk("b2b_y", {24'd0, y_r}, 32'h0F);

      // Forward with a single bubble
      push(8'h05, 8'h03, C_ADD_AB, 1'b0);
      push(8'h00, 8'h02, C_ADD_AB, 1'b1);
      idle(5);
      chk("fwd_a", {24'd0, o_a}, 32'h08);
      chk("fwd_y", {24'd0, y_r}, 32'h0A);

      // Fill the queue with a forwarded increment chain
      push(8'h20, 8'h00, C_ADD_AB, 1'b0);
      for (int i = 0; i < 6; i++) push(8'h00, 8'h00, C_INC_A, 1'b1);
      idle(20);
      chk("full_y", {24'd0, y_r}, 32'h26);

      // Ordered stream through pointer wrap
      for (int i = 1; i <= 10; i++) push(8'(i * 3), 8'(i), C_AND_AB, 1'b0);
      idle(4);
      chk("wrap_last_b", {24'd0, o_b}, 32'h0A);

      // Reset with entries queued
      push(8'h01, 8'h01, C_ADD_AB, 1'b0);
      push(8'h00, 8'h01, C_ADD_AB, 1'b1);
      push(8'h00, 8'h01, C_ADD_AB, 1'b1);
      push(8'h00, 8'h01, C_ADD_AB, 1'b1);
      step(1'b0, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, acc);
      push(8'h07, 8'h09, C_ADD_AB, 1'b0);
      idle(4);
      chk("post_reset_y", {24'd0, y_r}, 32'h10);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0),
              8'($urandom), 8'($urandom), 4'($urandom_range(0, 4)),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0), acc);
      end
      idle(10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
